// File: rtl/systolic_nxn_serial.sv
`default_nettype none
// ============================================================================
// Module   : systolic_nxn_serial
// Summary  : NxN matrix-vector job engine with bit-serial operand loading.
// Revision : 1.0
// ============================================================================
module systolic_nxn_serial #(
  parameter int N  = 4,
  parameter int DW = 4,
  parameter int AW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          keep_w,
  input  logic          signed_mode,
  input  logic [N-1:0]  bit_inputs,
  output logic          busy,
  output logic [AW-1:0] results [N-1:0],
  output logic          valid_out,
  output logic          done
);

  localparam int c_BW = $clog2(DW);
  localparam int c_SW = $clog2(N);
  localparam int c_CW = $clog2(2*N);
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DW-1);
  localparam logic [c_SW-1:0] c_SET_LAST = c_SW'(N-1);
  localparam logic [c_SW-1:0] c_SET_PEN  = c_SW'(N-2);
  localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(2*N-2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_X  = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_BW-1:0] r_bit;
  logic [c_SW-1:0] r_set;
  logic [c_CW-1:0] r_cyc;
  logic            r_signed;
  logic [DW-1:0]   r_w [N-1:0][N-1:0];
  logic [DW-1:0]   r_x [N-1:0][N-1:0];

  logic [c_SW-1:0] w_k;
  logic [AW-1:0]   w_beat [N-1:0];

  function automatic logic [AW-1:0] ext(input logic [DW-1:0] v, input logic sg);
    if (sg) return AW'($signed(v));
    return AW'(v);
  endfunction

  // Beat being prepared: beat 0 on the last compute edge, then the one after r_set.
  always_comb begin
    w_k = '0;
    if (r_state == S_OUTPUT && r_set != c_SET_LAST) w_k = r_set + 1'b1;
  end

  // Modular AW-bit arithmetic gives the low AW bits of the full-precision sum.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_beat[i] = '0;
      for (int j = 0; j < N; j++)
        w_beat[i] = w_beat[i] + ext(r_w[i][j], r_signed) * ext(r_x[w_k][j], r_signed);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_set     <= '0;
      r_cyc     <= '0;
      r_signed  <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        results[i] <= '0;
        for (int j = 0; j < N; j++) begin
          r_w[i][j] <= '0;
          r_x[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed <= signed_mode;
            r_bit    <= '0;
            r_set    <= '0;
            busy     <= 1'b1;
            r_state  <= keep_w ? S_LOAD_X : S_LOAD_W;
          end
        end
        S_LOAD_W, S_LOAD_X: begin
          for (int j = 0; j < N; j++) begin
            if (r_state == S_LOAD_W) r_w[r_set][j][r_bit] <= bit_inputs[j];
            else                     r_x[r_set][j][r_bit] <= bit_inputs[j];
          end
          if (r_bit == c_BIT_LAST) begin
            r_bit <= '0;
            if (r_set == c_SET_LAST) begin
              r_set <= '0;
              r_cyc <= '0;
              r_state <= (r_state == S_LOAD_W) ? S_LOAD_X : S_COMPUTE;
            end else begin
              r_set <= r_set + 1'b1;
            end
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (r_cyc == c_CYC_LAST) begin
            r_state   <= S_OUTPUT;
            r_set     <= '0;
            results   <= w_beat;
            valid_out <= 1'b1;
            done      <= 1'b0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (r_set == c_SET_LAST) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
          end else begin
            r_set   <= r_set + 1'b1;
            results <= w_beat;
            done    <= (r_set == c_SET_PEN);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_nxn_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_nxn_serial
// Summary  : Scoreboard bench for systolic_nxn_serial with a matrix-level model.
// Revision : 1.0
// ============================================================================
module tb_systolic_nxn_serial;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int AW = 2*DW + $clog2(N);

  logic          clk;
  logic          reset;
  logic          start;
  logic          keep_w;
  logic          signed_mode;
  logic [N-1:0]  bit_inputs;
  logic          busy;
  logic [AW-1:0] results [N-1:0];
  logic          valid_out;
  logic          done;

  systolic_nxn_serial #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .keep_w(keep_w),
    .signed_mode(signed_mode), .bit_inputs(bit_inputs), .busy(busy),
    .results(results), .valid_out(valid_out), .done(done)
  );

  typedef struct {
    int                    ecnt;
    logic [N-1:0][AW-1:0]  v;
    bit                    last;
  } beat_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            edge_cnt = 0;
  logic [DW-1:0] tw [N][N];
  logic [DW-1:0] tx [N][N];
  int            mw [N][N];
  beat_t         sbq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input bit sg);
    if (sg && v >= 2**(DW-1)) return v - 2**DW;
    return v;
  endfunction

  // Reference: results[i] of beat k = sum_j W[i][j]*X[k][j], kept to AW bits.
  task automatic push_job(input bit kw, input bit sg, input int e0);
    int    lat;
    int    s;
    beat_t b;
    if (!kw) for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mw[i][j] = int'(tw[i][j]);
    lat = (kw ? N*DW : 2*N*DW) + 2*N - 1;
    for (int k = 0; k < N; k++) begin
      b.ecnt = e0 + lat + k;
      for (int i = 0; i < N; i++) begin
        s = 0;
        for (int j = 0; j < N; j++) s += sx(mw[i][j], sg) * sx(int'(tx[k][j]), sg);
        b.v[i] = s[AW-1:0];
      end
      b.last = (k == N-1);
      sbq.push_back(b);
    end
  endtask

  task automatic run_job(input bit kw, input bit sg, input bit noise);
    int e0, len, idx, k, bt;
    keep_w = kw; signed_mode = sg; start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_cnt;
    start = 1'b0; keep_w = 1'($urandom); signed_mode = 1'($urandom);
    chk("busy_after_start", busy, 1);
    push_job(kw, sg, e0);
    len = kw ? N*DW : 2*N*DW;
    for (int e = 0; e < len; e++) begin
      idx = kw ? e + N*DW : e;
      for (int j = 0; j < N; j++) begin
        if (idx < N*DW) begin
          k = idx / DW; bt = idx % DW;
          bit_inputs[j] = tw[k][j][bt];
        end else begin
          k = (idx - N*DW) / DW; bt = (idx - N*DW) % DW;
          bit_inputs[j] = tx[k][j][bt];
        end
      end
      start = noise && (idx >= N*DW) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    // Compute and output phases: garbage on the bus and stray start pulses.
    for (int e = 0; e < 3*N-1; e++) begin
      bit_inputs = N'($urandom);
      start = noise && ($urandom_range(0, 1) == 0);
      keep_w = 1'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_after_job", busy, 0);
    chk("valid_after_job", valid_out, 0);
    chk("beats_outstanding", sbq.size(), 0);
  endtask

  task automatic reset_mid_job();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      tw[i][j] = DW'($urandom_range(1, 2**DW-1));
      tx[i][j] = DW'($urandom_range(1, 2**DW-1));
    end
    keep_w = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < 2*N*DW + 3; e++) begin
      bit_inputs = N'($urandom);
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_done", done, 0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_mid_results[%0d]", i), results[i], 0);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mw[i][j] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (valid_out) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", valid_out, 0);
        end else begin
          b = sbq.pop_front();
          chk("beat_edge", edge_cnt, b.ecnt);
          for (int i = 0; i < N; i++) chk($sformatf("results[%0d]", i), results[i], b.v[i]);
          chk("done_on_beat", done, b.last);
        end
      end else begin
        chk("done_without_valid", done, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; keep_w = 1'b0; signed_mode = 1'b0; bit_inputs = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mw[i][j] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_done", done, 0);
    for (int i = 0; i < N; i++) chk($sformatf("reset_results[%0d]", i), results[i], 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Weight 4*i+j+1; the value 16 does not fit in DW bits and loads as 0.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      tw[i][j] = DW'(4*i + j + 1);
      tx[i][j] = DW'(i + 1);
    end
    run_job(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) tx[i][j] = DW'(2);
    run_job(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      tw[i][j] = '1;
      tx[i][j] = DW'(1);
    end
    run_job(1'b0, 1'b1, 1'b0);
    run_job(1'b0, 1'b0, 1'b0);

    repeat (12) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        tw[i][j] = DW'($urandom);
        tx[i][j] = DW'($urandom);
      end
      run_job(1'($urandom), 1'($urandom), 1'($urandom));
    end

    reset_mid_job();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) tx[i][j] = DW'($urandom_range(1, 2**DW-1));
    run_job(1'b1, 1'($urandom), 1'b1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
